lu_blk_sender: RTL and testbench

LU_BLK_SENDER -- requirements
Module: lu_blk_sender

---
 rtl/lu_new.sv | 17 +
 rtl/lu_sfifo.sv | 50 +++++
 rtl/lu_blk_sender.sv | 123 ++++++++++++
 tb/tb_lu_blk_sender.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lu_new.sv
// Shared LU accelerator constants and the block-sender FSM state type.
package lu_new;

  localparam int unsigned BSIZE         = 64;
  localparam int unsigned BWORDSMEM     = 512;
  localparam int unsigned BWORDSMEMBITS = 9;
  localparam int unsigned CACHE_AWIDTH  = 12;
  localparam int unsigned CACHE_DWIDTH  = 256;
  localparam int unsigned NET_DWIDTH    = 256;

  typedef enum logic [1:0] {
    BS_IDLE,
    BS_RUN,
    BS_DRAIN
  } t_blk_send_state;

endpackage

// File: rtl/lu_sfifo.sv
// Synchronous skid FIFO with registered empty flag and occupancy count.
module lu_sfifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             empty_q;
  logic             do_wr, do_rd;

  assign do_rd   = rd_en_i && !empty_q;
  assign do_wr   = wr_en_i && ((count_q != (AW+1)'(DEPTH)) || do_rd);
  assign count_d = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = empty_q;
  assign count_o   = count_q;

endmodule

// File: rtl/lu_blk_sender.sv
// Streams one LU block from the cache to the network, credit-limited so the
// fixed-latency read pipeline can never overrun the output skid FIFO.
module lu_blk_sender
  import lu_new::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [CACHE_AWIDTH-1:0] cmd_base,
  output logic                    cache_rd_en,
  output logic [CACHE_AWIDTH-1:0] cache_rd_addr,
  input  logic [CACHE_DWIDTH-1:0] cache_rd_data,
  output logic                    net_valid,
  input  logic                    net_ready,
  output logic [NET_DWIDTH-1:0]   net_data,
  output logic                    net_sop,
  output logic                    net_eop,
  output logic                    busy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  t_blk_send_state          state_q, state_d;
  logic [CACHE_AWIDTH-1:0]  base_q, base_d;
  logic [BWORDSMEMBITS:0]   rd_cnt_q, rd_cnt_d;
  logic [BWORDSMEMBITS-1:0] out_cnt_q, out_cnt_d;
  logic [RD_LAT-1:0]        vld_q, vld_d;

  logic          cmd_fire, pop, push, last_rd, credit, fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   inflight, used;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign pop      = net_valid && net_ready;
  assign push     = vld_q[RD_LAT-1];
  assign last_rd  = cache_rd_en && (rd_cnt_q == (BWORDSMEMBITS+1)'(BWORDSMEM - 1));

  // A word leaving the FIFO this cycle already counts as a free slot.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      inflight = inflight + (CW+1)'(vld_q[i]);
    end
    used   = inflight + {1'b0, fifo_cnt} - (CW+1)'(pop);
    credit = (used < (CW+1)'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= BS_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BS_IDLE:  if (cmd_fire)          state_d = BS_RUN;
      BS_RUN:   if (last_rd)           state_d = BS_DRAIN;
      BS_DRAIN: if (pop && net_eop)    state_d = BS_IDLE;
      default:                         state_d = BS_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = (state_q == BS_IDLE);
    busy        = (state_q != BS_IDLE);
    cache_rd_en = (state_q == BS_RUN) && credit;
  end

  always_comb begin
    base_d    = base_q;
    rd_cnt_d  = rd_cnt_q + (BWORDSMEMBITS+1)'(cache_rd_en);
    out_cnt_d = out_cnt_q + BWORDSMEMBITS'(pop);
    if (cmd_fire) begin
      base_d    = cmd_base;
      rd_cnt_d  = '0;
      out_cnt_d = '0;
    end
    vld_d    = '0;
    vld_d[0] = cache_rd_en;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q    <= '0;
      rd_cnt_q  <= '0;
      out_cnt_q <= '0;
      vld_q     <= '0;
    end else begin
      base_q    <= base_d;
      rd_cnt_q  <= rd_cnt_d;
      out_cnt_q <= out_cnt_d;
      vld_q     <= vld_d;
    end
  end

  assign cache_rd_addr = base_q + CACHE_AWIDTH'(rd_cnt_q);

  lu_sfifo #(
    .WIDTH (CACHE_DWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (push),
    .wr_data_i (cache_rd_data),
    .rd_en_i   (pop),
    .rd_data_o (net_data),
    .empty_o   (fifo_empty),
    .count_o   (fifo_cnt)
  );

  assign net_valid = !fifo_empty;
  assign net_sop   = net_valid && (out_cnt_q == '0);
  assign net_eop   = net_valid && (out_cnt_q == BWORDSMEMBITS'(BWORDSMEM - 1));

endmodule

// File: tb/tb_lu_blk_sender.sv
// Directed bench for lu_blk_sender with a 2-cycle cache model and a network-side monitor.
module tb_lu_blk_sender;
  import lu_new::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [11:0]  cmd_base = '0;
  logic         cache_rd_en;
  logic [11:0]  cache_rd_addr;
  logic [255:0] cache_rd_data;
  logic         net_valid;
  logic         net_ready = 1'b1;
  logic [255:0] net_data;
  logic         net_sop, net_eop, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lu_blk_sender #(.FIFO_DEPTH(4), .RD_LAT(2)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cache_rd_en(cache_rd_en), .cache_rd_addr(cache_rd_addr),
    .cache_rd_data(cache_rd_data), .net_valid(net_valid), .net_ready(net_ready),
    .net_data(net_data), .net_sop(net_sop), .net_eop(net_eop), .busy(busy)
  );

  function automatic logic [255:0] word_of(input logic [11:0] a);
    return {16{4'h5, a}};
  endfunction

  // Cache model: data valid exactly two cycles after the strobe; not reset.
  logic        v1 = 1'b0, v2 = 1'b0;
  logic [11:0] a1 = '0, a2 = '0;
  always @(posedge clk) begin
    v1 <= cache_rd_en; a1 <= cache_rd_addr;
    v2 <= v1;          a2 <= a1;
  end
  assign cache_rd_data = v2 ? word_of(a2) : {32{8'hEE}};

  // Monitor: records issued addresses and accepted words, tracks stalls.
  logic [255:0] got_data[$];
  logic         got_sop[$], got_eop[$];
  int           got_cyc[$];
  logic [11:0]  iss_addr[$];
  int cyc = 0, issued = 0, popped = 0, max_out = 0, stall_viol = 0, stalls = 0;
  logic         prev_stall = 1'b0, prev_sop = 1'b0, prev_eop = 1'b0;
  logic [255:0] prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      issued = 0; popped = 0; prev_stall = 1'b0;
    end else begin
      if (issued - popped > max_out) max_out = issued - popped;
      if (prev_stall && (net_valid !== 1'b1 || net_data !== prev_data ||
                         net_sop !== prev_sop || net_eop !== prev_eop))
        stall_viol++;
      if (cache_rd_en) begin issued++; iss_addr.push_back(cache_rd_addr); end
      if (net_valid && net_ready) begin
        popped++;
        got_data.push_back(net_data); got_sop.push_back(net_sop);
        got_eop.push_back(net_eop);   got_cyc.push_back(cyc);
      end
      if (net_valid && !net_ready) stalls++;
      prev_stall = net_valid && !net_ready;
      prev_data  = net_data; prev_sop = net_sop; prev_eop = net_eop;
    end
  end

  function automatic int bad_words(input int s, input logic [11:0] base);
    int bad = 0;
    for (int i = 0; i < 512; i++) begin
      logic [11:0] a = base + 12'(i);
      if (s + i >= got_data.size()) bad++;
      else if (got_data[s+i] !== word_of(a) || got_sop[s+i] !== (i == 0) ||
               got_eop[s+i] !== (i == 511)) bad++;
    end
    return bad;
  endfunction

  function automatic int bad_addrs(input int s, input logic [11:0] base);
    int bad = 0;
    for (int i = 0; i < 512; i++) begin
      logic [11:0] a = base + 12'(i);
      if (s + i >= iss_addr.size()) bad++;
      else if (iss_addr[s+i] !== a) bad++;
    end
    return bad;
  endfunction

  task automatic start_cmd(input logic [11:0] base, output int ok);
    @(posedge clk); #1 cmd_valid = 1'b1; cmd_base = base;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int ok);
    ok = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; net_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (cache_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", cache_rd_en); end
    checks++; if (cache_rd_addr !== 12'h000) begin errors++; $display("FAIL reset_rd_addr got=%h exp=000", cache_rd_addr); end
    checks++; if (net_valid !== 1'b0) begin errors++; $display("FAIL reset_net_valid got=%b exp=0", net_valid); end
    checks++; if (net_sop !== 1'b0 || net_eop !== 1'b0) begin errors++; $display("FAIL reset_sop_eop got=%b%b exp=00", net_sop, net_eop); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    int s, sa, ok, k;
    net_ready = 1'b1;
    s = got_data.size(); sa = iss_addr.size();
    start_cmd(12'h100, ok);
    checks++; if (ok !== 1) begin errors++; $display("FAIL basic_accept got=%0d exp=1", ok); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (net_valid) begin k = i; break; end
    end
    checks++; if (k !== 3) begin errors++; $display("FAIL basic_first_valid_edges got=%0d exp=3", k); end
    wait_idle(ok);
    checks++; if (ok !== 1) begin errors++; $display("FAIL basic_idle_timeout got=%0d exp=1", ok); end
    checks++; if (got_data.size() - s !== 512) begin errors++; $display("FAIL basic_count got=%0d exp=512", got_data.size() - s); end
    checks++; if (bad_words(s, 12'h100) !== 0) begin errors++; $display("FAIL basic_words bad=%0d exp=0", bad_words(s, 12'h100)); end
    checks++; if (bad_addrs(sa, 12'h100) !== 0) begin errors++; $display("FAIL basic_addrs bad=%0d exp=0", bad_addrs(sa, 12'h100)); end
    if (got_cyc.size() >= s + 512) begin
      checks++;
      if (got_cyc[s+511] - got_cyc[s] !== 511) begin errors++; $display("FAIL basic_consecutive span=%0d exp=511", got_cyc[s+511] - got_cyc[s]); end
    end
  endtask

  task automatic test_wrap();
    int s, sa, ok;
    net_ready = 1'b1;
    s = got_data.size(); sa = iss_addr.size();
    start_cmd(12'hF00, ok);
    wait_idle(ok);
    checks++; if (ok !== 1) begin errors++; $display("FAIL wrap_idle_timeout got=%0d exp=1", ok); end
    checks++; if (bad_addrs(sa, 12'hF00) !== 0) begin errors++; $display("FAIL wrap_addrs bad=%0d exp=0", bad_addrs(sa, 12'hF00)); end
    if (iss_addr.size() >= sa + 257) begin
      checks++;
      if (iss_addr[sa+255] !== 12'hFFF || iss_addr[sa+256] !== 12'h000) begin
        errors++; $display("FAIL wrap_boundary got=%h,%h exp=fff,000", iss_addr[sa+255], iss_addr[sa+256]);
      end
    end
    checks++; if (bad_words(s, 12'hF00) !== 0) begin errors++; $display("FAIL wrap_words bad=%0d exp=0", bad_words(s, 12'hF00)); end
  endtask

  task automatic test_stall();
    int s, sa, ok;
    net_ready = 1'b0;
    s = got_data.size(); sa = iss_addr.size();
    start_cmd(12'h2A0, ok);
    repeat (100) @(negedge clk);
    checks++; if (iss_addr.size() - sa !== 4) begin errors++; $display("FAIL stall_reads got=%0d exp=4", iss_addr.size() - sa); end
    checks++; if (cache_rd_en !== 1'b0) begin errors++; $display("FAIL stall_rd_en got=%b exp=0", cache_rd_en); end
    checks++; if (net_valid !== 1'b1 || net_sop !== 1'b1 || net_data !== word_of(12'h2A0)) begin
      errors++; $display("FAIL stall_head valid=%b sop=%b data=%h exp=1 1 %h", net_valid, net_sop, net_data, word_of(12'h2A0));
    end
    @(posedge clk); #1 net_ready = 1'b1;
    wait_idle(ok);
    checks++; if (bad_words(s, 12'h2A0) !== 0 || got_data.size() - s !== 512) begin
      errors++; $display("FAIL stall_words bad=%0d count=%0d exp=0 512", bad_words(s, 12'h2A0), got_data.size() - s);
    end
  endtask

  task automatic test_random_ready();
    int s, ok, sv, st;
    s = got_data.size(); sv = stall_viol; st = stalls;
    start_cmd(12'h0C3, ok);
    ok = 0;
    for (int i = 0; i < 8000; i++) begin
      @(posedge clk); #1 net_ready = ($urandom_range(0, 9) < 3);
      if (!busy) begin ok = 1; break; end
    end
    net_ready = 1'b1;
    checks++; if (ok !== 1) begin errors++; $display("FAIL rand_idle_timeout got=%0d exp=1", ok); end
    checks++; if (got_data.size() - s !== 512) begin errors++; $display("FAIL rand_count got=%0d exp=512", got_data.size() - s); end
    checks++; if (bad_words(s, 12'h0C3) !== 0) begin errors++; $display("FAIL rand_words bad=%0d exp=0", bad_words(s, 12'h0C3)); end
    checks++; if (stall_viol - sv !== 0 || stalls - st == 0) begin
      errors++; $display("FAIL rand_stable viol=%0d stalls=%0d exp=0 >0", stall_viol - sv, stalls - st);
    end
    checks++; if (max_out > 4) begin errors++; $display("FAIL rand_credit max=%0d exp<=4", max_out); end
  endtask

  task automatic test_back_to_back();
    int s, ok;
    logic prev_eop_fire, ready_after_eop;
    net_ready = 1'b1;
    s = got_data.size();
    start_cmd(12'h040, ok);
    #0 cmd_valid = 1'b1; cmd_base = 12'h300;
    prev_eop_fire = 1'b0; ready_after_eop = 1'b0; ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ready_after_eop = prev_eop_fire; ok = 1; break; end
      prev_eop_fire = net_valid && net_ready && net_eop;
    end
    checks++; if (ok !== 1 || ready_after_eop !== 1'b1) begin
      errors++; $display("FAIL b2b_ready_timing seen=%0d after_eop=%b exp=1 1", ok, ready_after_eop);
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_idle(ok);
    checks++; if (got_data.size() - s !== 1024) begin errors++; $display("FAIL b2b_count got=%0d exp=1024", got_data.size() - s); end
    checks++; if (bad_words(s, 12'h040) !== 0) begin errors++; $display("FAIL b2b_first bad=%0d exp=0", bad_words(s, 12'h040)); end
    checks++; if (bad_words(s + 512, 12'h300) !== 0) begin errors++; $display("FAIL b2b_second bad=%0d exp=0", bad_words(s + 512, 12'h300)); end
  endtask

  task automatic test_reset_mid();
    int s, s2, ok, eops, late;
    net_ready = 1'b1;
    s = got_data.size();
    start_cmd(12'h200, ok);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (got_data.size() - s >= 200) begin ok = 1; break; end
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || cache_rd_en !== 1'b0 || cache_rd_addr !== 12'h000) begin
      errors++; $display("FAIL mid_reset_ctrl ready=%b busy=%b rd_en=%b addr=%h exp=1 0 0 000", cmd_ready, busy, cache_rd_en, cache_rd_addr);
    end
    checks++; if (net_valid !== 1'b0 || net_sop !== 1'b0 || net_eop !== 1'b0) begin
      errors++; $display("FAIL mid_reset_net valid=%b sop=%b eop=%b exp=0 0 0", net_valid, net_sop, net_eop);
    end
    late = 0;
    repeat (6) begin @(negedge clk); if (net_valid !== 1'b0) late++; end
    checks++; if (late !== 0) begin errors++; $display("FAIL mid_late_data valid_cycles=%0d exp=0", late); end
    s2 = got_data.size();
    eops = 0;
    for (int i = s; i < s2; i++) if (got_eop[i]) eops++;
    checks++; if (eops !== 0 || ok !== 1) begin errors++; $display("FAIL mid_abandon eops=%0d reached=%0d exp=0 1", eops, ok); end
    start_cmd(12'h000, ok);
    wait_idle(ok);
    checks++; if (got_data.size() - s2 !== 512 || bad_words(s2, 12'h000) !== 0) begin
      errors++; $display("FAIL mid_restart count=%0d bad=%0d exp=512 0", got_data.size() - s2, bad_words(s2, 12'h000));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog sim_time=%0t exp=finish_before_limit", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_random_ready();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
